// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU for the stage between issue and writeback.
//   The simple ops (AND/OR/ADD/SUB/SLT) have a one-cycle registered latency.
//   The iterative ops take WIDTH cycles: MUL/MULHU use shift-add and
//   DIVU/REMU use restoring shift-subtract.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   request handshake (op, a, b are captured on accept)
//   out_valid / out_ready result handshake (out, zero, of, dz)
//   op                    4-bit opcode; codes not listed below are illegal and give 0
//   a, b                  WIDTH-bit operands
//   out                   WIDTH-bit result
//   zero                  out == 0
//   of                    signed overflow (ADD/SUB only)
//   dz                    divide by zero (DIVU/REMU with b == 0)
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             of,
  output logic             dz
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // The state an accepted opcode moves to. Illegal codes go to DONE, like the simple ops.
  function automatic state_t entry_state(input logic [3:0] o);
    state_t s;
    case (o)
      OP_MUL, OP_MULHU: s = S_MUL_RUN;
      OP_DIVU, OP_REMU: s = S_DIV_RUN;
      default:          s = S_DONE;
    endcase
    return s;
  endfunction

  // One-cycle ops. The return value is {overflow, result}.
  function automatic logic [WIDTH:0] simple_op(input logic [3:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             ovf;
    sum  = x + y;
    diff = x + ~y + {{(WIDTH-1){1'b0}}, 1'b1};
    res  = '0;
    ovf  = 1'b0;
    case (o)
      OP_AND: res = x & y;
      OP_OR:  res = x | y;
      OP_ADD: begin
        res = sum;
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      // SLT takes the raw sign bit of the wrapped difference, with no overflow correction.
      OP_SLT: res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
    return {ovf, res};
  endfunction

  state_t               state_r, state_n_s;
  logic [3:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     rem_r, quo_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     out_r;
  logic                 zero_r, of_r, dz_r;

  logic                 in_ready_s, accept_s, last_s, running_s;
  logic [WIDTH:0]       simple_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s, div_diff_s;
  logic                 div_ge_s;
  logic [WIDTH-1:0]     rem_next_s, quo_next_s, fin_s;

  // Handshake decode and the per-cycle steps of the iterative datapath.
  always_comb begin
    in_ready_s  = (state_r == S_IDLE) || ((state_r == S_DONE) && out_ready);
    accept_s    = in_valid && in_ready_s;
    last_s      = (cnt_r == CNT_W'(WIDTH - 1));
    running_s   = (state_r == S_MUL_RUN) || (state_r == S_DIV_RUN);
    simple_s    = simple_op(op, a, b);
    // acc_r holds {partial product high half, unconsumed multiplier bits}.
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    // quo_r starts as the dividend and shifts quotient bits in from the right.
    // When b == 0 every trial subtract succeeds, which gives quotient = all ones and remainder = a.
    div_shift_s = {rem_r, quo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    div_diff_s  = div_shift_s - {1'b0, b_r};
    rem_next_s  = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
    quo_next_s  = {quo_r[WIDTH-2:0], div_ge_s};
    if (state_r == S_MUL_RUN) begin
      fin_s = (op_r == OP_MUL) ? mul_next_s[WIDTH-1:0] : mul_next_s[2*WIDTH-1:WIDTH];
    end else begin
      fin_s = (op_r == OP_DIVU) ? quo_next_s : rem_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_n_s = entry_state(op);
        else          state_n_s = S_IDLE;
      end
      S_MUL_RUN: begin
        if (last_s) state_n_s = S_DONE;
        else        state_n_s = S_MUL_RUN;
      end
      S_DIV_RUN: begin
        if (last_s) state_n_s = S_DONE;
        else        state_n_s = S_DIV_RUN;
      end
      S_DONE: begin
        if (accept_s)       state_n_s = entry_state(op);
        else if (out_ready) state_n_s = S_IDLE;
        else                state_n_s = S_DONE;
      end
      default: state_n_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_n_s;
  end

  // Operand capture, iteration registers and the registered result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= 4'b0000;
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      cnt_r  <= '0;
      out_r  <= '0;
      zero_r <= 1'b0;
      of_r   <= 1'b0;
      dz_r   <= 1'b0;
    end else if (accept_s) begin
      op_r  <= op;
      a_r   <= a;
      b_r   <= b;
      cnt_r <= '0;
      acc_r <= {{WIDTH{1'b0}}, b};
      quo_r <= a;
      rem_r <= '0;
      if (entry_state(op) == S_DONE) begin
        out_r  <= simple_s[WIDTH-1:0];
        zero_r <= (simple_s[WIDTH-1:0] == '0);
        of_r   <= simple_s[WIDTH];
        dz_r   <= 1'b0;
      end
    end else if (running_s) begin
      cnt_r <= last_s ? '0 : cnt_r + CNT_W'(1);
      if (state_r == S_MUL_RUN) begin
        acc_r <= mul_next_s;
      end else begin
        rem_r <= rem_next_s;
        quo_r <= quo_next_s;
      end
      if (last_s) begin
        out_r  <= fin_s;
        zero_r <= (fin_s == '0);
        of_r   <= 1'b0;
        dz_r   <= (state_r == S_DIV_RUN) && (b_r == '0);
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == S_DONE);
  assign out       = out_r;
  assign zero      = zero_r;
  assign of        = of_r;
  assign dz        = dz_r;

endmodule
